// File: rtl/odu_slot_scheduler.sv
// odu_slot_scheduler: round-robin payload-slot scheduler aligned to the ODU row stream.
// Define ODU_SLOT_STUFF_STATS_EN to add the per-row stuff beat counter output o_stuff_count.
module odu_slot_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int ROW_BEATS = 82
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_odu_valid,
    input  logic               i_odu_rs,
    input  logic [7:0]         i_odu_mfas,
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_id,
    output logic               o_grant_valid,
    output logic               o_stuff,
    output logic               o_oh,
    output logic [6:0]         o_row_beat,
    output logic               o_aligned,
    output logic               o_align_err
`ifdef ODU_SLOT_STUFF_STATS_EN
    ,output logic [6:0]        o_stuff_count
`endif
);
    typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;
    state_t state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d, gid_q, gid_d, hit_id, nxt_id;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [6:0] cnt_q, cnt_d, exp_cnt;
    logic gv_q, gv_d, stuff_q, stuff_d, oh_q, oh_d, err_q, err_d;
    logic hit, acc, wrap;
    int idx;
`ifdef ODU_SLOT_STUFF_STATS_EN
    logic [6:0] sc_q, sc_d, so_q, so_d;
`endif
    // Descending scan so the lowest offset from the pointer wins.
    always_comb begin
        hit = 1'b0;
        hit_id = '0;
        idx = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (i_req[idx]) begin
                hit = 1'b1;
                hit_id = ID_W'(idx);
            end
        end
    end
    assign nxt_id  = (hit_id == ID_W'(NUM_REQ - 1)) ? '0 : hit_id + ID_W'(1);
    assign exp_cnt = (cnt_q == 7'(ROW_BEATS - 1)) ? 7'd0 : cnt_q + 7'd1;
    assign wrap    = (exp_cnt == 7'd0);
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        grant_d = '0;
        gid_d = '0;
        gv_d = 1'b0;
        stuff_d = 1'b0;
        oh_d = 1'b0;
        err_d = 1'b0;
        acc = 1'b0;
`ifdef ODU_SLOT_STUFF_STATS_EN
        sc_d = sc_q;
        so_d = so_q;
`endif
        if (!i_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:  state_d = ALIGN;
                ALIGN: acc = i_odu_valid & i_odu_rs;
                RUN: if (i_odu_valid) begin
                    if (i_odu_rs != wrap) begin
                        err_d = 1'b1;
                        acc = i_odu_rs;
                        state_d = i_odu_rs ? RUN : ALIGN;
`ifdef ODU_SLOT_STUFF_STATS_EN
                        sc_d = '0;
`endif
                    end else if (i_odu_rs) begin
                        acc = 1'b1;
`ifdef ODU_SLOT_STUFF_STATS_EN
                        so_d = sc_q;
`endif
                    end else begin
                        cnt_d = exp_cnt;
                        gv_d = hit;
                        stuff_d = ~hit;
                        gid_d = hit ? hit_id : '0;
                        grant_d = hit ? NUM_REQ'(1) << hit_id : '0;
                        ptr_d = hit ? nxt_id : ptr_q;
`ifdef ODU_SLOT_STUFF_STATS_EN
                        sc_d = hit ? sc_q : ((sc_q == 7'd127) ? sc_q : sc_q + 7'd1);
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // An accepted rs beat becomes beat 0; mfas 0 restarts the rotation.
        if (acc) begin
            state_d = RUN;
            oh_d = 1'b1;
            cnt_d = '0;
            ptr_d = (i_odu_mfas == 8'd0) ? '0 : ptr_q;
`ifdef ODU_SLOT_STUFF_STATS_EN
            sc_d = '0;
`endif
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            cnt_q <= '0;
            grant_q <= '0;
            gid_q <= '0;
            gv_q <= 1'b0;
            stuff_q <= 1'b0;
            oh_q <= 1'b0;
            err_q <= 1'b0;
`ifdef ODU_SLOT_STUFF_STATS_EN
            sc_q <= '0;
            so_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            grant_q <= grant_d;
            gid_q <= gid_d;
            gv_q <= gv_d;
            stuff_q <= stuff_d;
            oh_q <= oh_d;
            err_q <= err_d;
`ifdef ODU_SLOT_STUFF_STATS_EN
            sc_q <= sc_d;
            so_q <= so_d;
`endif
        end
    end
    assign o_grant       = grant_q;
    assign o_grant_id    = gid_q;
    assign o_grant_valid = gv_q;
    assign o_stuff       = stuff_q;
    assign o_oh          = oh_q;
    assign o_row_beat    = cnt_q;
    assign o_aligned     = (state_q == RUN);
    assign o_align_err   = err_q;
`ifdef ODU_SLOT_STUFF_STATS_EN
    assign o_stuff_count = so_q;
`endif
endmodule

// File: doc/odu_slot_scheduler.md
Name: odu_slot_scheduler

Overview:
- Round-robin payload-slot scheduler for the 384-bit ODU row stream produced by the ODU generator.
- Tracks row alignment from the generator's row-start (rs), valid and MFAS outputs.
- Grants each payload beat to one of NUM_REQ tributary requesters, or marks the beat as stuff when no requester is pending.
- Sits between the ODU generator and the tributary mux; the mux selects data from the granted requester's output.

Parameters:
- NUM_REQ, 4, number of tributary requesters (2..8).
- ID_W, 2, width of the grant index; must equal clog2(NUM_REQ), minimum 1.
- ROW_BEATS, 82, valid beats per ODU row, including the rs overhead beat (range 3..127).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_enable  in  1  scheduler enable; low forces IDLE.
- i_odu_valid  in  1  ODU beat valid.
- i_odu_rs  in  1  row-start (overhead beat); sampled only when i_odu_valid=1.
- i_odu_mfas  in  8  MFAS of the current row; sampled only on rs beats.
- i_req  in  NUM_REQ  per-requester pending flag (level).
- o_grant  out  NUM_REQ  one-hot grant for the beat; all zero on overhead, stuff or idle.
- o_grant_id  out  ID_W  index of the granted requester; 0 when o_grant=0.
- o_grant_valid  out  1  one payload beat granted this cycle.
- o_stuff  out  1  payload beat with no requester pending.
- o_oh  out  1  overhead beat (no grant).
- o_row_beat  out  7  beat index within the row: 0 = rs beat, up to ROW_BEATS-1.
- o_aligned  out  1  high while in RUN.
- o_align_err  out  1  one-cycle pulse on an rs/beat-count mismatch.

Behaviour:
- Clock and reset: one clock, i_clk. i_rst is synchronous and active-high.
- Reset values: all outputs 0, round-robin pointer 0, beat counter 0, state IDLE. Reset mid-row discards the row; no outputs appear until realignment.
- States:
  - IDLE: leave to ALIGN when i_enable=1.
  - ALIGN: wait for a beat with valid=1 and rs=1, then go to RUN and treat that beat as beat 0.
  - RUN: count every valid beat.
  - In any state, i_enable=0 goes to IDLE at the next edge.
- Beat counter (RUN only):
  - Increments on each valid beat and wraps from ROW_BEATS-1 to 0.
  - Does not advance on valid=0 cycles.
  - rs is expected exactly when the counter wraps to 0.
  - rs at any other beat, or no rs at the wrap beat: pulse o_align_err, go to ALIGN, issue no grant for that beat.
  - Exception: if the erroring beat itself carries rs, ALIGN accepts it immediately as beat 0 (direct RUN restart, err still pulses).
- Output latency: exactly 1 cycle. Outputs for input beat k appear on the cycle after k is sampled, registered. Cycles without a valid beat drive o_grant=0 and o_grant_valid=o_stuff=o_oh=0; o_row_beat holds its value.
- Overhead beat (rs): o_oh=1, no grant, pointer unchanged. If i_odu_mfas==0, the pointer resets to 0 so each multiframe starts deterministically.
- Payload beat:
  - Search i_req starting at the pointer, ascending with wrap modulo NUM_REQ.
  - On a hit at index j: o_grant[j]=1, o_grant_id=j, o_grant_valid=1, pointer becomes (j+1) mod NUM_REQ.
  - No request pending: o_stuff=1, pointer unchanged.
  - Exactly one of o_oh, o_stuff or o_grant_valid is high per emitted beat.
- A requester deasserting i_req in the same cycle it would win is simply not granted; there is no grant holding.
- i_req bits at index NUM_REQ and above do not exist; the pointer never exceeds NUM_REQ-1.

Optional Feature:
- Macro: ODU_SLOT_STUFF_STATS_EN.
- Defined: adds output o_stuff_count, 7 bits.
  - Internal counter counts o_stuff beats within the current row, saturating at 127.
  - On each rs beat in RUN, the value is copied into o_stuff_count and the counter clears.
  - Reset value 0. An alignment error clears the internal counter without updating the output.
- Not defined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Basic rotation: reset, i_enable=1, i_req=4'b1111, continuous valid beats with rs every 82nd beat and mfas=0. Required: first rs beat gives o_oh=1 at 1-cycle latency; payload grant_id sequence 0,1,2,3,0,…; 81 grants per row; o_row_beat runs 0..81.
- Sparse requests: i_req=4'b0101. Required: grant_id alternates 2,0,2,0; no stuff. i_req=0 for 5 payload beats gives 5 o_stuff pulses with the pointer unchanged.
- Alignment error: rs injected at beat 40. Required: o_align_err pulses once, o_aligned stays high (rs restarts as beat 0). rs withheld at the wrap beat: o_align_err pulses, o_aligned drops, and no grants issue until the next rs beat.
- MFAS reset: pointer at 3 when an rs beat arrives with mfas=0. Required: first payload grant goes to 0. With mfas=64, the first grant goes to 3.
- Gaps and disable: valid=0 for 3 cycles mid-row. Required: o_row_beat holds, no outputs. i_enable=0 for one cycle, then i_rst pulsed mid-row: all outputs 0 on the next cycle, and RUN re-entered only after a fresh rs beat.
- Stats (ODU_SLOT_STUFF_STATS_EN defined): i_req=0 for 10 payload beats of a row. Required: o_stuff_count=10 after the next rs beat.
